step_sequencer: RTL and testbench

//  Parametrised pattern step sequencer: the next-generation drum-machine core.

---
 rtl/step_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_step_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Pattern step sequencer: writable pattern RAM, clamped tempo control,
// iterative step-period divider and one sample trigger per step.
module step_sequencer #(
  parameter int unsigned STEPS    = 32,
  parameter int unsigned N_PAT    = 4,
  parameter int unsigned SAMPLE_W = 3,
  parameter int unsigned BPM_RST  = 140,
  parameter int unsigned BPM_MIN  = 60,
  parameter int unsigned BPM_MAX  = 250,
  parameter int unsigned BPM_INC  = 5,
  parameter int unsigned MS_NUM   = 30000,
  localparam int unsigned PW      = $clog2(N_PAT),
  localparam int unsigned SW      = $clog2(STEPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_ms,
  input  logic                run,
  input  logic                bpm_up,
  input  logic                bpm_dn,
  input  logic [PW-1:0]       pat_sel,
  input  logic                wr_en,
  input  logic [PW-1:0]       wr_pat,
  input  logic [SW-1:0]       wr_step,
  input  logic [SAMPLE_W-1:0] wr_data,
  output logic [7:0]          bpm,
  output logic [9:0]          period_ms,
  output logic                calc_busy,
  output logic [SW-1:0]       step_idx,
  output logic [PW-1:0]       pat_idx,
  output logic                step_stb,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                trig
);

  localparam int unsigned DIV_N      = 16;
  localparam logic [9:0]  PERIOD_RST = 10'(MS_NUM / BPM_RST);

  typedef enum logic [1:0] {ST_STOP, ST_START, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [8:0]          bpm_sum;
  logic [7:0]          bpm_dif, bpm_nxt;
  logic                bpm_chg;
  logic [3:0]          div_cnt;
  logic [15:0]         div_q;
  logic [7:0]          div_d, div_r, div_sub;
  logic [8:0]          div_sh;
  logic                div_ge;
  logic [9:0]          ms_cnt, ms_nxt;
  logic [SW-1:0]       step_nxt;
  logic [PW-1:0]       pat_nxt, pat_pend;
  logic                emit;
  logic [SAMPLE_W-1:0] rd_data;
  logic [SAMPLE_W-1:0] ram [N_PAT*STEPS];

  // Tempo: clamped up/down, simultaneous pulses cancel
  always_comb begin
    bpm_sum = {1'b0, bpm} + 9'(BPM_INC);
    bpm_dif = bpm - 8'(BPM_INC);
    bpm_nxt = bpm;
    if (bpm_up && !bpm_dn)
      bpm_nxt = (bpm_sum > 9'(BPM_MAX)) ? 8'(BPM_MAX) : bpm_sum[7:0];
    else if (bpm_dn && !bpm_up)
      bpm_nxt = ({1'b0, bpm} < 9'(BPM_MIN + BPM_INC)) ? 8'(BPM_MIN) : bpm_dif;
    bpm_chg = (bpm_nxt != bpm);
  end

  // Restoring divider; remainder always fits 8 bits since it stays below the divisor
  always_comb begin
    div_sh  = {div_r, div_q[15]};
    div_ge  = (div_sh >= {1'b0, div_d});
    div_sub = div_sh[7:0] - div_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bpm       <= 8'(BPM_RST);
      period_ms <= PERIOD_RST;
      calc_busy <= 1'b0;
      div_cnt   <= '0;
      div_q     <= '0;
      div_d     <= '0;
      div_r     <= '0;
    end else begin
      bpm <= bpm_nxt;
      if (bpm_chg) begin
        calc_busy <= 1'b1;
        div_cnt   <= '0;
        div_q     <= 16'(MS_NUM);
        div_d     <= bpm_nxt;
        div_r     <= '0;
      end else if (calc_busy) begin
        div_q   <= {div_q[14:0], div_ge};
        div_r   <= div_ge ? div_sub : div_sh[7:0];
        div_cnt <= div_cnt + 4'd1;
        if (div_cnt == 4'(DIV_N - 1)) begin
          calc_busy <= 1'b0;
          period_ms <= {div_q[8:0], div_ge};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_STOP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP:  if (run) state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   if (!run) state_nxt = ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
  end

  // Step decision; the pending pattern is adopted only on the wrap to step 0
  always_comb begin
    emit     = 1'b0;
    step_nxt = step_idx;
    pat_nxt  = pat_idx;
    ms_nxt   = ms_cnt;
    case (state)
      ST_STOP: begin
        step_nxt = '0;
        ms_nxt   = '0;
        pat_nxt  = pat_sel;
      end
      ST_START: begin
        emit     = 1'b1;
        step_nxt = '0;
        ms_nxt   = '0;
      end
      ST_RUN: begin
        if (tick_ms) begin
          if (ms_cnt >= period_ms - 10'd1) begin
            ms_nxt = '0;
            emit   = 1'b1;
            if (step_idx == SW'(STEPS - 1)) begin
              step_nxt = '0;
              pat_nxt  = pat_pend;
            end else begin
              step_nxt = step_idx + SW'(1);
            end
          end else begin
            ms_nxt = ms_cnt + 10'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign rd_data = ram[{pat_nxt, step_nxt}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_idx   <= '0;
      pat_idx    <= '0;
      pat_pend   <= '0;
      ms_cnt     <= '0;
      step_stb   <= 1'b0;
      sample_out <= '0;
      trig       <= 1'b0;
    end else begin
      step_idx <= step_nxt;
      pat_idx  <= pat_nxt;
      pat_pend <= pat_sel;
      ms_cnt   <= ms_nxt;
      step_stb <= emit;
      trig     <= emit && (rd_data != '0);
      if (emit) sample_out <= rd_data;
    end
  end

  // Pattern RAM is intentionally not reset; read-during-write returns old data
  always_ff @(posedge clk) begin
    if (wr_en) ram[{wr_pat, wr_step}] <= wr_data;
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: reset, tempo clamp/divider, step timing,
// pattern switching, RAM playback and mid-run reset.
`timescale 1ns/1ps
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       rst, tick_ms, run, bpm_up, bpm_dn, wr_en;
  logic [1:0] pat_sel, wr_pat, pat_idx;
  logic [4:0] wr_step, step_idx;
  logic [2:0] wr_data, sample_out;
  logic [7:0] bpm;
  logic [9:0] period_ms;
  logic       calc_busy, step_stb, trig;
  logic       tick_en = 1'b0;
  int         ticks = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  step_sequencer dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .run(run),
    .bpm_up(bpm_up), .bpm_dn(bpm_dn), .pat_sel(pat_sel),
    .wr_en(wr_en), .wr_pat(wr_pat), .wr_step(wr_step), .wr_data(wr_data),
    .bpm(bpm), .period_ms(period_ms), .calc_busy(calc_busy),
    .step_idx(step_idx), .pat_idx(pat_idx), .step_stb(step_stb),
    .sample_out(sample_out), .trig(trig)
  );

  // 1 ms strobe modelled as a pulse every other clock
  initial begin
    tick_ms = 1'b0;
    forever begin
      @(negedge clk);
      tick_ms = tick_en && !tick_ms;
    end
  end

  always @(posedge clk) if (tick_ms) ticks <= ticks + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] p, input logic [4:0] s, input logic [2:0] d);
    wr_en = 1'b1; wr_pat = p; wr_step = s; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse(input logic up, input logic dn, input int gap);
    bpm_up = up; bpm_dn = dn;
    @(negedge clk);
    bpm_up = 1'b0; bpm_dn = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_stb(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (step_stb) begin ok = 1'b1; break; end
    end
    check("stb_seen", ok, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!calc_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("div_done", ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    rst = 1'b1; run = 1'b0; bpm_up = 1'b0; bpm_dn = 1'b0; pat_sel = '0;
    wr_en = 1'b0; wr_pat = '0; wr_step = '0; wr_data = '0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_bpm", bpm, 140);
    check("rst_period", period_ms, 214);
    check("rst_busy", calc_busy, 0);
    check("rst_step", step_idx, 0);
    check("rst_pat", pat_idx, 0);
    check("rst_stb", step_stb, 0);
    check("rst_sample", sample_out, 0);
    check("rst_trig", trig, 0);

    wr(0, 0, 1); wr(0, 1, 2); wr(0, 31, 6); wr(2, 0, 7);
    wr(1, 0, 3); wr(1, 3, 5); wr(1, 4, 0);

    // Step timing and pattern switch in one bar
    run = 1'b1; tick_en = 1'b1;
    @(negedge clk);
    check("start_stb_low", step_stb, 0);
    @(negedge clk);
    check("s0_stb", step_stb, 1);
    check("s0_step", step_idx, 0);
    check("s0_sample", sample_out, 1);
    check("s0_trig", trig, 1);
    t0 = ticks;
    wait_stb(600);
    check("tick_gap", ticks - t0, 214);
    check("s1_step", step_idx, 1);
    check("s1_sample", sample_out, 2);
    cyc(1);
    check("s1_stb_pulse", step_stb, 0);
    check("s1_trig_pulse", trig, 0);
    check("s1_sample_held", sample_out, 2);
    for (int s = 2; s <= 5; s++) wait_stb(600);
    check("s5_step", step_idx, 5);
    pat_sel = 2'd2;
    for (int s = 6; s <= 31; s++) wait_stb(600);
    check("s31_step", step_idx, 31);
    check("s31_pat", pat_idx, 0);
    check("s31_sample", sample_out, 6);
    wait_stb(600);
    check("wrap_step", step_idx, 0);
    check("wrap_pat", pat_idx, 2);
    check("wrap_sample", sample_out, 7);
    check("wrap_trig", trig, 1);

    // RAM playback of pattern 1
    run = 1'b0;
    cyc(2);
    pat_sel = 2'd1;
    cyc(2);
    check("stop_pat", pat_idx, 1);
    check("stop_step", step_idx, 0);
    run = 1'b1;
    cyc(2);
    check("p1s0_stb", step_stb, 1);
    check("p1s0_sample", sample_out, 3);
    for (int s = 1; s <= 3; s++) wait_stb(600);
    check("p1s3_step", step_idx, 3);
    check("p1s3_sample", sample_out, 5);
    check("p1s3_trig", trig, 1);
    cyc(1);
    check("p1s3_trig_fall", trig, 0);
    check("p1s3_sample_held", sample_out, 5);
    wait_stb(600);
    check("p1s4_step", step_idx, 4);
    check("p1s4_sample", sample_out, 0);
    check("p1s4_trig", trig, 0);
    run = 1'b0;
    cyc(3);

    // Tempo and divider
    pulse(1, 1, 1);
    check("updn_bpm", bpm, 140);
    check("updn_busy", calc_busy, 0);
    for (int i = 0; i < 22; i++) pulse(1, 0, 2);
    wait_idle(40);
    check("max_bpm", bpm, 250);
    check("max_period", period_ms, 120);
    pulse(1, 0, 1);
    check("clamp_hi_bpm", bpm, 250);
    check("clamp_hi_busy", calc_busy, 0);
    pulse(0, 1, 1);
    check("dn_bpm", bpm, 245);
    check("dn_busy", calc_busy, 1);
    check("dn_old_period", period_ms, 120);
    n = 1;
    while (calc_busy && n < 40) begin
      @(negedge clk);
      if (calc_busy) n++;
    end
    check("div_cycles", n, 16);
    check("dn_period", period_ms, 122);
    for (int i = 0; i < 37; i++) pulse(0, 1, 1);
    wait_idle(40);
    check("min_bpm", bpm, 60);
    check("min_period", period_ms, 500);
    pulse(0, 1, 1);
    check("clamp_lo_bpm", bpm, 60);
    check("clamp_lo_busy", calc_busy, 0);

    // Reset mid-run, run held high through release
    run = 1'b1;
    cyc(2);
    check("e_s0_stb", step_stb, 1);
    wait_stb(1200);
    check("e_s1_step", step_idx, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_bpm", bpm, 140);
    check("mrst_period", period_ms, 214);
    check("mrst_step", step_idx, 0);
    check("mrst_stb", step_stb, 0);
    check("mrst_busy", calc_busy, 0);
    rst = 1'b0;
    cyc(2);
    check("restart_stb", step_stb, 1);
    check("restart_step", step_idx, 0);
    check("restart_pat", pat_idx, 1);
    check("restart_sample", sample_out, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
